d_ff_pipe: RTL and testbench

Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline (delay line) with a per-stage valid bit, clock enable (stall), synchronous flush, a programmable reset value and a live occupancy count. It delays data/valid pairs by exactly DEPTH enabled clocks. It is the generic retiming/delay element for datapaths that need more than one bit, more than one stage, or stall/flush control.

---
 rtl/d_ff_pipe.sv | 68 ++++++
 tb/tb_d_ff_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ff_pipe.sv
// d_ff_pipe: DEPTH-stage, WIDTH-bit delay line with a per-stage valid bit, stall (en),
// synchronous flush, programmable reset value and a live count of valid stages.
module d_ff_pipe #(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      DEPTH        = 4,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter bit               ZERO_INVALID = 1'b0
) (
   input  logic                       clk,
   input  logic                       Rst,
   input  logic                       en,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           D,
   input  logic                       d_valid,
   output logic [WIDTH-1:0]           Q,
   output logic                       q_valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned CW1 = CW + 1;

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   always_comb begin
      // NOTE: every signal written here is defaulted first, so no path can leave one unassigned and infer a latch.
      data_d  = data_q;
      vld_d   = vld_q;
      count_d = count_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) data_d[i] = RESET_VAL;
         vld_d   = '0;
         count_d = '0;
      end else if (en) begin
         data_d[0] = (ZERO_INVALID && !d_valid) ? RESET_VAL : D;
         vld_d[0]  = d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
         // One extra bit keeps the transient add/subtract from wrapping; the result fits in CW bits.
         count_d = CW'({1'b0, count_q} + CW1'(d_valid) - CW1'(vld_q[DEPTH-1]));
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage samples its neighbour's pre-edge value.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         // NOTE: the stages are discrete flops rather than a RAM, so each one is reset to RESET_VAL.
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
         vld_q   <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         vld_q   <= vld_d;
         count_q <= count_d;
      end
   end

   assign Q       = data_q[DEPTH-1];
   assign q_valid = vld_q[DEPTH-1];
   assign count   = count_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
// Bench for d_ff_pipe: two instances (ZERO_INVALID=0/1) share stimulus; a queue scoreboard
// tracks each pipeline, and each scenario task adds its own fixed-value comparisons.
module tb_d_ff_pipe;
   localparam int         DP = 4;
   localparam logic [7:0] RV = 8'hA5;

   typedef struct {
      logic [7:0] data;
      logic       vld;
   } entry_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       flush;
   logic [7:0] D;
   logic       d_valid;
   logic [7:0] q0, q1;
   logic       qv0, qv1;
   logic [2:0] cnt0, cnt1;

   entry_t sb0[$];
   entry_t sb1[$];
   int     checks   = 0;
   int     failures = 0;

   always #5 clk = ~clk;

   d_ff_pipe #(.WIDTH(8), .DEPTH(DP), .RESET_VAL(RV), .ZERO_INVALID(1'b0)) dut_zi0 (
      .clk(clk), .Rst(rst_n), .en(en), .flush(flush), .D(D), .d_valid(d_valid),
      .Q(q0), .q_valid(qv0), .count(cnt0)
   );

   d_ff_pipe #(.WIDTH(8), .DEPTH(DP), .RESET_VAL(RV), .ZERO_INVALID(1'b1)) dut_zi1 (
      .clk(clk), .Rst(rst_n), .en(en), .flush(flush), .D(D), .d_valid(d_valid),
      .Q(q1), .q_valid(qv1), .count(cnt1)
   );

   // Scoreboard entry 0 is the oldest sample, i.e. the one presented on Q.
   task automatic sb_reset();
      sb0.delete();
      sb1.delete();
      for (int i = 0; i < DP; i++) begin
         sb0.push_back('{RV, 1'b0});
         sb1.push_back('{RV, 1'b0});
      end
   endtask

   function automatic int popcnt(input entry_t q[$]);
      int n = 0;
      foreach (q[i]) n += int'(q[i].vld);
      return n;
   endfunction

   task automatic step(input logic e, input logic f, input logic [7:0] d, input logic dv);
      en = e; flush = f; D = d; d_valid = dv;
      @(posedge clk);
      if (rst_n) begin
         if (f) sb_reset();
         else if (e) begin
            sb0.delete(0);
            sb0.push_back('{d, dv});
            sb1.delete(0);
            sb1.push_back('{(dv ? d : RV), dv});
         end
      end
      #1;
      checks++;
      if (q0 !== sb0[0].data || qv0 !== sb0[0].vld || cnt0 !== 3'(popcnt(sb0))) begin
         failures++;
         $display("FAIL scoreboard_zi0 t=%0t got Q=%h v=%b count=%0d want Q=%h v=%b count=%0d",
                  $time, q0, qv0, cnt0, sb0[0].data, sb0[0].vld, popcnt(sb0));
      end
      checks++;
      if (q1 !== sb1[0].data || qv1 !== sb1[0].vld || cnt1 !== 3'(popcnt(sb1))) begin
         failures++;
         $display("FAIL scoreboard_zi1 t=%0t got Q=%h v=%b count=%0d want Q=%h v=%b count=%0d",
                  $time, q1, qv1, cnt1, sb1[0].data, sb1[0].vld, popcnt(sb1));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sb_reset();
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'h3C, 1'b1);
      step(1'b1, 1'b0, 8'h3D, 1'b1);
      // Drop reset between edges; outputs must follow without a clock edge.
      rst_n = 1'b0;
      sb_reset();
      #1;
      checks++;
      if ({q0, qv0, cnt0} !== {RV, 1'b0, 3'd0} || {q1, qv1, cnt1} !== {RV, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_immediate got Q=%h/%h v=%b/%b count=%0d/%0d want Q=a5 v=0 count=0",
                  q0, q1, qv0, qv1, cnt0, cnt1);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 8'hC3, 1'b1);
         checks++;
         if ({q0, qv0, cnt0} !== {RV, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_hold edge=%0d got Q=%h v=%b count=%0d want Q=a5 v=0 count=0",
                     k, q0, qv0, cnt0);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_latency_fill();
      int exp_cnt[5] = '{1, 2, 3, 4, 4};
      step(1'b0, 1'b1, 8'h00, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 1'b0, 8'(k), 1'b1);
         checks++;
         if (cnt0 !== 3'(exp_cnt[k-1])) begin
            failures++;
            $display("FAIL fill_count edge=%0d got %0d want %0d", k, cnt0, exp_cnt[k-1]);
         end
         checks++;
         if ((k < 4 && qv0 !== 1'b0) || (k == 4 && {q0, qv0} !== {8'h01, 1'b1}) ||
             (k == 5 && {q0, qv0} !== {8'h02, 1'b1})) begin
            failures++;
            $display("FAIL fill_latency edge=%0d got Q=%h v=%b", k, q0, qv0);
         end
      end
   endtask

   task automatic test_stall();
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h11, 1'b1);
      step(1'b1, 1'b0, 8'h22, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 8'hEE, 1'b1);
         checks++;
         if ({q0, qv0, cnt0} !== {RV, 1'b0, 3'd2}) begin
            failures++;
            $display("FAIL stall_hold edge=%0d got Q=%h v=%b count=%0d want Q=a5 v=0 count=2",
                     k, q0, qv0, cnt0);
         end
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if (qv0 !== 1'b0) begin
         failures++;
         $display("FAIL stall_early got v=%b want 0", qv0);
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if ({q0, qv0, cnt0} !== {8'h11, 1'b1, 3'd2}) begin
         failures++;
         $display("FAIL stall_resume got Q=%h v=%b count=%0d want Q=11 v=1 count=2", q0, qv0, cnt0);
      end
   endtask

   task automatic test_flush_priority();
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h40 + 8'(k), 1'b1);
      checks++;
      if (cnt0 !== 3'd4) begin
         failures++;
         $display("FAIL flush_full got count=%0d want 4", cnt0);
      end
      step(1'b1, 1'b1, 8'hFF, 1'b1);
      checks++;
      if ({q0, qv0, cnt0} !== {RV, 1'b0, 3'd0} || {q1, qv1, cnt1} !== {RV, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL flush_clear got Q=%h/%h v=%b/%b count=%0d/%0d want Q=a5 v=0 count=0",
                  q0, q1, qv0, qv1, cnt0, cnt1);
      end
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0);
         checks++;
         if (q0 === 8'hFF || qv0 !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard edge=%0d got Q=%h v=%b want Q!=ff v=0", k, q0, qv0);
         end
      end
   endtask

   task automatic test_bubbles();
      logic [7:0] d_tab  [6] = '{8'h10, 8'h77, 8'h30, 8'h00, 8'h00, 8'h00};
      logic       dv_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [8:0] exp0   [3] = '{{8'h10, 1'b1}, {8'h77, 1'b0}, {8'h30, 1'b1}};
      logic [8:0] exp1   [3] = '{{8'h10, 1'b1}, {8'hA5, 1'b0}, {8'h30, 1'b1}};
      step(1'b0, 1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, d_tab[k], dv_tab[k]);
         checks++;
         if (cnt0 > 3'd2 || cnt1 > 3'd2) begin
            failures++;
            $display("FAIL bubble_count edge=%0d got count=%0d/%0d want <=2", k, cnt0, cnt1);
         end
         if (k >= 3) begin
            checks++;
            if ({q0, qv0} !== exp0[k-3] || {q1, qv1} !== exp1[k-3]) begin
               failures++;
               $display("FAIL bubble_out edge=%0d got zi0=%h/%b zi1=%h/%b want zi0=%h/%b zi1=%h/%b",
                        k, q0, qv0, q1, qv1, exp0[k-3][8:1], exp0[k-3][0], exp1[k-3][8:1], exp1[k-3][0]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, 1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h61 + 8'(k), 1'b1);
      checks++;
      if (cnt0 !== 3'd3) begin
         failures++;
         $display("FAIL async_pre got count=%0d want 3", cnt0);
      end
      en = 1'b1; d_valid = 1'b1; D = 8'h64;
      rst_n = 1'b0;
      sb_reset();
      #1;
      checks++;
      if ({q0, qv0, cnt0} !== {RV, 1'b0, 3'd0} || {q1, qv1, cnt1} !== {RV, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL async_immediate got Q=%h/%h v=%b/%b count=%0d/%0d want Q=a5 v=0 count=0",
                  q0, q1, qv0, qv1, cnt0, cnt1);
      end
      step(1'b1, 1'b0, 8'h64, 1'b1);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'h5A, 1'b1);
      for (int k = 2; k <= 4; k++) begin
         checks++;
         if (qv0 !== 1'b0) begin
            failures++;
            $display("FAIL async_latency edge=%0d got v=%b want 0", k - 1, qv0);
         end
         step(1'b1, 1'b0, 8'h00, 1'b0);
      end
      checks++;
      if ({q0, qv0, cnt0} !== {8'h5A, 1'b1, 3'd1}) begin
         failures++;
         $display("FAIL async_arrive got Q=%h v=%b count=%0d want Q=5a v=1 count=1", q0, qv0, cnt0);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; flush = 1'b0; D = 8'h00; d_valid = 1'b0;
      sb_reset();
      test_reset();
      test_latency_fill();
      test_stall();
      test_flush_priority();
      test_bubbles();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
